// File: rtl/alu_seq.sv
// Sequential ALU: one op per valid/ready handshake, registered result and flags.
// Keeps an internal carry for ADDC chains; shifts and MUL iterate in BUSY.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             carry_q
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NEG  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_CLRC = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;

  logic               accept;
  logic               is_shift;
  logic [SHW-1:0]     n_sat;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     addc_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   sll_nxt;
  logic [WIDTH-1:0]   sra_nxt;
  logic               load;
  logic [WIDTH-1:0]   res_val;
  logic               c_val;

  assign accept   = in_valid && in_ready;
  assign is_shift = (op == OP_SLL) || (op == OP_SRA);
  assign n_sat    = (32'(b) >= 32'(WIDTH)) ? SHW'(WIDTH) : SHW'(b);
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign addc_sum = add_sum + {{WIDTH{1'b0}}, carry_q};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign sll_nxt  = {work_q[WIDTH-2:0], 1'b0};
  assign sra_nxt  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};

  // Shift-add step: add multiplicand into the high half, then shift right.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, work_q} : '0);
  assign prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ((is_shift && n_sat != '0) || op == OP_MUL)
            state_d = S_BUSY;
          else
            state_d = S_DONE;
        end
      end
      S_BUSY: begin
        if (cnt_q == SHW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    op_d     = op_q;
    work_d   = work_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    load     = 1'b0;
    res_val  = '0;
    c_val    = 1'b0;
    if (state_q == S_IDLE && accept) begin
      op_d = op;
      unique case (1'b1)
        (op == OP_ADD): begin
          load    = 1'b1;
          res_val = add_sum[WIDTH-1:0];
          c_val   = add_sum[WIDTH];
          carry_d = add_sum[WIDTH];
        end
        (op == OP_ADDC): begin
          load    = 1'b1;
          res_val = addc_sum[WIDTH-1:0];
          c_val   = addc_sum[WIDTH];
          carry_d = addc_sum[WIDTH];
        end
        (op == OP_SUB): begin
          load    = 1'b1;
          res_val = sub_diff[WIDTH-1:0];
          c_val   = sub_diff[WIDTH];
          carry_d = sub_diff[WIDTH];
        end
        is_shift: begin
          if (n_sat == '0) begin
            load    = 1'b1;
            res_val = a;
          end else begin
            work_d = a;
            cnt_d  = n_sat;
          end
        end
        (op == OP_MUL): begin
          work_d = a;
          prod_d = {{WIDTH{1'b0}}, b};
          cnt_d  = SHW'(WIDTH);
        end
        (op == OP_AND): begin
          load    = 1'b1;
          res_val = a & b;
        end
        (op == OP_OR): begin
          load    = 1'b1;
          res_val = a | b;
        end
        (op == OP_NEG): begin
          load    = 1'b1;
          res_val = ~a;
        end
        (op == OP_CLRC): begin
          load    = 1'b1;
          carry_d = 1'b0;
        end
        default: begin
          load = 1'b1;
        end
      endcase
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - SHW'(1);
      unique case (1'b1)
        (op_q == OP_SLL): begin
          work_d  = sll_nxt;
          res_val = sll_nxt;
          c_val   = work_q[WIDTH-1];
        end
        (op_q == OP_SRA): begin
          work_d  = sra_nxt;
          res_val = sra_nxt;
          c_val   = work_q[0];
        end
        default: begin
          prod_d  = prod_nxt;
          res_val = prod_nxt[WIDTH-1:0];
          c_val   = |prod_nxt[2*WIDTH-1:WIDTH];
        end
      endcase
      load = (cnt_q == SHW'(1));
    end
  end

  always_comb begin
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    if (load) begin
      result_d = res_val;
      cout_d   = c_val;
      zero_d   = (res_val == '0);
      neg_d    = res_val[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      work_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      work_q   <= work_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign neg    = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): driver pushes expected results,
// monitor pops and compares whenever out_valid is presented.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
  logic       zero;
  logic       neg;
  logic       carry_q;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .carry_q   (carry_q)
  );

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
    logic       cy;
    int         lat;
    int         hold;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] o,
                       input logic [7:0] aa, input logic [7:0] bb,
                       input logic [7:0] r, input logic c,
                       input logic z, input logic n, input logic cy,
                       input int lat, input int hold);
    exp_t e;
    int   w;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a  = aa;
    b  = bb;
    w  = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept timeout in_ready 0 required 1", nm);
      in_valid = 1'b0;
      return;
    end
    e.name = nm;
    e.res  = r;
    e.c    = c;
    e.z    = z;
    e.n    = n;
    e.cy   = cy;
    e.lat  = lat;
    e.hold = hold;
    e.acc  = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a  = 8'($urandom);
    b  = 8'($urandom);
  endtask

  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got %0h expected none", result);
        end else begin
          e = q.pop_front();
          check({e.name, "_lat"}, 16'(cyc - e.acc), 16'(e.lat));
          check({e.name, "_res"}, 16'(result), 16'(e.res));
          check({e.name, "_cout"}, 16'(cout), 16'(e.c));
          check({e.name, "_zero"}, 16'(zero), 16'(e.z));
          check({e.name, "_neg"}, 16'(neg), 16'(e.n));
          check({e.name, "_carry"}, 16'(carry_q), 16'(e.cy));
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            check({e.name, "_hold_valid"}, 16'(out_valid), 16'd1);
            check({e.name, "_hold_res"}, 16'(result), 16'(e.res));
            check({e.name, "_hold_rdy"}, 16'(in_ready), 16'd0);
          end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handshake_drop", 16'(out_valid), 16'd0);
      end
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || !in_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op = 4'd0;
    a  = 8'd0;
    b  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_result", 16'(result), 16'd0);
    check("rst_flags", 16'({cout, zero, neg, carry_q}), 16'd0);
    rst_n = 1'b1;

    //     name        op     a      b      res    c  z  n  cy lat hold
    issue("add_f0_20", 4'd0, 8'hF0, 8'h20, 8'h10, 1, 0, 0, 1, 1, 3);
    issue("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1, 1, 0);
    issue("addc_chain", 4'd1, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 1, 0);
    issue("add_ff_01b", 4'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1, 1, 0);
    issue("clrc", 4'd9, 8'h5A, 8'hA5, 8'h00, 0, 1, 0, 0, 1, 0);
    issue("addc_clr", 4'd1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1, 0);
    issue("sub_3_5", 4'd2, 8'h03, 8'h05, 8'hFE, 1, 0, 1, 1, 1, 1);
    issue("sra_80_3", 4'd4, 8'h80, 8'h03, 8'hF0, 0, 0, 1, 1, 4, 0);
    issue("sll_81_9", 4'd3, 8'h81, 8'h09, 8'h00, 1, 1, 0, 1, 9, 0);
    issue("sll_81_0", 4'd3, 8'h81, 8'h00, 8'h81, 0, 0, 1, 1, 1, 0);
    issue("rsvd_c", 4'd12, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 1, 1, 0);
    issue("mul_10_11", 4'd8, 8'h10, 8'h11, 8'h10, 1, 0, 0, 1, 9, 2);
    issue("and", 4'd5, 8'hCC, 8'hAA, 8'h88, 0, 0, 1, 1, 1, 0);
    issue("or", 4'd6, 8'h0C, 8'h0A, 8'h0E, 0, 0, 0, 1, 1, 0);
    issue("neg", 4'd7, 8'h0F, 8'h33, 8'hF0, 0, 0, 1, 1, 1, 0);
    issue("sra_85_20", 4'd4, 8'h85, 8'd20, 8'hFF, 1, 0, 1, 1, 9, 0);
    issue("sra_40_2", 4'd4, 8'h40, 8'h02, 8'h10, 0, 0, 0, 1, 3, 0);
    issue("mul_0f_0f", 4'd8, 8'h0F, 8'h0F, 8'hE1, 0, 0, 1, 1, 9, 0);
    issue("add_12_34", 4'd0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 1, 0);
    issue("addc_nc", 4'd1, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 0, 1, 0);
    drain();

    // Abort a MUL in its fourth cycle with reset.
    @(negedge clk);
    in_valid = 1'b1;
    op = 4'd8;
    a  = 8'h10;
    b  = 8'h11;
    check("abort_accept_rdy", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_busy_valid", 16'(out_valid), 16'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_in_ready", 16'(in_ready), 16'd1);
    check("abort_result", 16'(result), 16'd0);
    check("abort_flags", 16'({cout, zero, neg, carry_q}), 16'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_result", 16'(out_valid), 16'd0);

    issue("post_add", 4'd0, 8'h80, 8'h80, 8'h00, 1, 1, 0, 1, 1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
